// File: rtl/arm_pkg.sv
// Shared encodings for the handshaked multicycle ARM controller: FSM states,
// opcode classes, datapath mux selects and condition codes.
package arm_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_FPUEX, S_FPUWB, S_FAULT
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_FP  = 2'b11;

    localparam logic [1:0] SRCA_RD1 = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;
    localparam logic [1:0] SRCA_PC8 = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/arm_condcheck.sv
// ARM condition evaluation of Cond against the NZCV register (combinational).
module arm_condcheck
    import arm_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = i_nzcv;

    always_comb begin
        o_cond_ex = 1'b1;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            default: o_cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/arm_mc_ctrl_hs.sv
// Multicycle ARM control FSM that stalls on memory/FPU handshakes; a bounded
// wait counter sends hung accesses to a FAULT state left only by reset.
module arm_mc_ctrl_hs
    import arm_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter bit FPU_EN   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [27:0] i_instr,
    input  logic [3:0]  i_alu_flags,
    input  logic        i_mem_ready,
    input  logic        i_fpu_done,
    output logic        o_mem_req,
    output logic        o_pc_write,
    output logic        o_mem_write,
    output logic        o_reg_write,
    output logic        o_ir_write,
    output logic        o_fpu_write,
    output logic        o_fpu_start,
    output logic        o_adr_src,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_result_src,
    output logic        o_alu_op,
    output logic        o_fault
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] W_MAX = CW'(WAIT_MAX);

    state_t          r_state, w_next;
    logic [3:0]      r_nzcv;
    logic [CW-1:0]   r_wait_cnt;
    logic            w_wait, w_cond_ex;
    logic [3:0]      w_cond, w_rd;
    logic [1:0]      w_op;
    logic [5:0]      w_funct;
    logic            w_mem_req, w_pc_write, w_mem_write, w_reg_write;
    logic            w_ir_write, w_fpu_write, w_fpu_start;
    logic            w_unused;

    assign w_cond  = i_instr[27:24];
    assign w_op    = i_instr[23:22];
    assign w_funct = i_instr[21:16];
    assign w_rd    = i_instr[11:8];
    assign w_unused = ^{i_instr[15:12], i_instr[7:0], w_funct[4:1]};

    arm_condcheck u_condcheck (
        .i_cond    (w_cond),
        .i_nzcv    (r_nzcv),
        .o_cond_ex (w_cond_ex)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_nzcv     <= 4'b0000;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ALUWB && w_funct[0])
                r_nzcv <= i_alu_flags;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_wait)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_wait       = 1'b0;
        w_mem_req    = 1'b0;
        w_pc_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_fpu_write  = 1'b0;
        w_fpu_start  = 1'b0;
        o_adr_src    = 1'b0;
        o_alu_src_a  = SRCA_RD1;
        o_alu_src_b  = SRCB_RD2;
        o_result_src = RES_ALUOUT;
        o_alu_op     = 1'b0;
        o_fault      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                o_alu_src_a  = SRCA_PC;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALURES;
                if (i_mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else begin
                    w_wait = 1'b1;
                end
            end
            S_DECODE: begin
                o_alu_src_a = SRCA_PC;
                o_alu_src_b = SRCB_FOUR;
                if (!w_cond_ex)
                    w_next = S_FETCH;
                else begin
                    case (w_op)
                        OP_DP:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
                        OP_MEM:  w_next = S_MEMADR;
                        OP_BR:   w_next = S_BRANCH;
                        default: w_next = FPU_EN ? S_FPUEX : S_FAULT;
                    endcase
                end
            end
            S_MEMADR: begin
                o_alu_src_b = SRCB_IMM;
                w_next      = w_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                o_adr_src = 1'b1;
                if (i_mem_ready) w_next = S_MEMWB;
                else             w_wait = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                o_result_src = RES_DATA;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                o_adr_src   = 1'b1;
                if (i_mem_ready) w_next = S_FETCH;
                else             w_wait = 1'b1;
            end
            S_EXECR: begin
                o_alu_op = 1'b1;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                o_alu_op    = 1'b1;
                o_alu_src_b = SRCB_IMM;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_pc_write  = (w_rd == 4'd15);
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a  = SRCA_PC8;
                o_alu_src_b  = SRCB_IMM;
                o_result_src = RES_ALURES;
                w_pc_write   = 1'b1;
                w_next       = S_FETCH;
            end
            S_FPUEX: begin
                // counter is cleared on entry, so zero marks the first cycle
                w_fpu_start = (r_wait_cnt == '0);
                if (i_fpu_done) w_next = S_FPUWB;
                else            w_wait = 1'b1;
            end
            S_FPUWB: begin
                w_fpu_write = 1'b1;
                w_next      = S_FETCH;
            end
            default: begin
                o_fault = 1'b1;
                w_next  = S_FAULT;
            end
        endcase
        if (w_wait && r_wait_cnt == W_MAX)
            w_next = S_FAULT;
    end

    // enables are held off for the whole reset so an aborted access cannot write
    assign o_mem_req   = w_mem_req   & ~i_reset;
    assign o_pc_write  = w_pc_write  & ~i_reset;
    assign o_mem_write = w_mem_write & ~i_reset;
    assign o_reg_write = w_reg_write & ~i_reset;
    assign o_ir_write  = w_ir_write  & ~i_reset;
    assign o_fpu_write = w_fpu_write & ~i_reset;
    assign o_fpu_start = w_fpu_start & ~i_reset;

endmodule

// File: tb/tb_arm_mc_ctrl_hs.sv
// Scoreboard bench: stimulus pushes the expected per-cycle control word, a
// negedge monitor pops and compares it for an FPU-enabled and an FPU-less DUT.
module tb_arm_mc_ctrl_hs;

    typedef struct packed {
        logic       fault, mem_req, pc_write, mem_write, reg_write, ir_write;
        logic       fpu_write, fpu_start, adr_src, alu_op;
        logic [1:0] src_a, src_b, res;
    } outs_t;

    typedef struct {
        outs_t exp;
        outs_t mask;
        outs_t exp2;
        string name;
    } chk_t;

    // field order: fault mreq pcw mw rw irw fw fs adr aluop srca srcb res
    localparam outs_t O_RST = 16'h0000;
    localparam outs_t O_FW  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b10};
    localparam outs_t O_FR  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b10};
    localparam outs_t O_DEC = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00};
    localparam outs_t O_MAD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00};
    localparam outs_t O_MRD = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
    localparam outs_t O_MWB = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b01};
    localparam outs_t O_MWR = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
    localparam outs_t O_EXR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00};
    localparam outs_t O_EXI = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00};
    localparam outs_t O_AWB = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
    localparam outs_t O_AWP = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
    localparam outs_t O_BR  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10};
    localparam outs_t O_FXS = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00};
    localparam outs_t O_FXI = 16'h0000;
    localparam outs_t O_FWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
    localparam outs_t O_FLT = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
    localparam outs_t M_ALL = 16'hFFFF;
    localparam outs_t M_EN  = {1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] instr = '0;
    logic [3:0]  flags = '0;
    logic        mready = 1'b1;
    logic        fdone = 1'b0;
    logic        d2_flt = 1'b0;

    outs_t got1, got2;
    chk_t  q[$];
    chk_t  c_m;
    int    n_tests = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    arm_mc_ctrl_hs #(.WAIT_MAX(15), .FPU_EN(1'b1)) dut (
        .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_alu_flags(flags),
        .i_mem_ready(mready), .i_fpu_done(fdone),
        .o_mem_req(got1.mem_req), .o_pc_write(got1.pc_write), .o_mem_write(got1.mem_write),
        .o_reg_write(got1.reg_write), .o_ir_write(got1.ir_write), .o_fpu_write(got1.fpu_write),
        .o_fpu_start(got1.fpu_start), .o_adr_src(got1.adr_src), .o_alu_src_a(got1.src_a),
        .o_alu_src_b(got1.src_b), .o_result_src(got1.res), .o_alu_op(got1.alu_op),
        .o_fault(got1.fault)
    );

    arm_mc_ctrl_hs #(.WAIT_MAX(15), .FPU_EN(1'b0)) dut_nofpu (
        .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_alu_flags(flags),
        .i_mem_ready(mready), .i_fpu_done(fdone),
        .o_mem_req(got2.mem_req), .o_pc_write(got2.pc_write), .o_mem_write(got2.mem_write),
        .o_reg_write(got2.reg_write), .o_ir_write(got2.ir_write), .o_fpu_write(got2.fpu_write),
        .o_fpu_start(got2.fpu_start), .o_adr_src(got2.adr_src), .o_alu_src_a(got2.src_a),
        .o_alu_src_b(got2.src_b), .o_result_src(got2.res), .o_alu_op(got2.alu_op),
        .o_fault(got2.fault)
    );

    function automatic logic [27:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        return {cond, op, funct, 4'h0, rd, 8'h00};
    endfunction

    task automatic step(input logic r, input logic [27:0] ins, input logic [3:0] fl,
                        input logic mr, input logic fd, input outs_t e, input string nm);
        chk_t c;
        @(posedge clk);
        #1;
        rst = r; instr = ins; flags = fl; mready = mr; fdone = fd;
        c.exp  = e;
        c.mask = r ? M_EN : M_ALL;
        c.exp2 = d2_flt ? O_FLT : e;
        c.name = nm;
        q.push_back(c);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            c_m = q.pop_front();
            n_tests++;
            if ((got1 & c_m.mask) !== (c_m.exp & c_m.mask)) begin
                n_fail++;
                $display("FAIL %s (FPU_EN=1): got %h want %h mask %h", c_m.name, got1, c_m.exp, c_m.mask);
            end
            n_tests++;
            if ((got2 & c_m.mask) !== (c_m.exp2 & c_m.mask)) begin
                n_fail++;
                $display("FAIL %s (FPU_EN=0): got %h want %h mask %h", c_m.name, got2, c_m.exp2, c_m.mask);
            end
        end
    end

    initial begin
        logic [27:0] add_s_r3, beq, ldr, addi_s_pc, str_eq, str_al, fop;
        add_s_r3  = mk(4'hE, 2'b00, 6'b001001, 4'd3);
        beq       = mk(4'h0, 2'b10, 6'b100000, 4'd0);
        ldr       = mk(4'hE, 2'b01, 6'b011001, 4'd1);
        addi_s_pc = mk(4'hE, 2'b00, 6'b101001, 4'd15);
        str_eq    = mk(4'h0, 2'b01, 6'b011000, 4'd2);
        str_al    = mk(4'hE, 2'b01, 6'b011000, 4'd2);
        fop       = mk(4'hE, 2'b11, 6'b000000, 4'd4);

        for (int i = 0; i < 3; i++) step(1'b1, '0, 4'h0, 1'b1, 1'b0, O_RST, "reset_hold");

        step(1'b0, add_s_r3, 4'b0100, 1'b1, 1'b0, O_FR,  "add_fetch");
        step(1'b0, add_s_r3, 4'b0100, 1'b1, 1'b0, O_DEC, "add_decode");
        step(1'b0, add_s_r3, 4'b0100, 1'b1, 1'b0, O_EXR, "add_execr");
        step(1'b0, add_s_r3, 4'b0100, 1'b1, 1'b0, O_AWB, "add_aluwb");

        step(1'b0, beq, 4'h0, 1'b1, 1'b0, O_FR,  "beq_fetch");
        step(1'b0, beq, 4'h0, 1'b1, 1'b0, O_DEC, "beq_decode");
        step(1'b0, beq, 4'h0, 1'b1, 1'b0, O_BR,  "beq_branch");

        step(1'b0, ldr, 4'h0, 1'b1, 1'b0, O_FR,  "ldr_fetch");
        step(1'b0, ldr, 4'h0, 1'b1, 1'b0, O_DEC, "ldr_decode");
        step(1'b0, ldr, 4'h0, 1'b1, 1'b0, O_MAD, "ldr_memadr");
        for (int i = 0; i < 5; i++) step(1'b0, ldr, 4'h0, 1'b0, 1'b0, O_MRD, "ldr_memrd_stall");
        step(1'b0, ldr, 4'h0, 1'b1, 1'b0, O_MRD, "ldr_memrd_done");
        step(1'b0, ldr, 4'h0, 1'b1, 1'b0, O_MWB, "ldr_memwb");

        step(1'b0, addi_s_pc, 4'b0000, 1'b1, 1'b0, O_FR,  "addi_fetch");
        step(1'b0, addi_s_pc, 4'b0000, 1'b1, 1'b0, O_DEC, "addi_decode");
        step(1'b0, addi_s_pc, 4'b0000, 1'b1, 1'b0, O_EXI, "addi_execi");
        step(1'b0, addi_s_pc, 4'b0000, 1'b1, 1'b0, O_AWP, "addi_aluwb_pc");

        step(1'b0, str_eq, 4'h0, 1'b1, 1'b0, O_FR,  "streq_fetch");
        step(1'b0, str_eq, 4'h0, 1'b1, 1'b0, O_DEC, "streq_decode_nop");

        step(1'b0, str_al, 4'h0, 1'b1, 1'b0, O_FR,  "str_fetch");
        step(1'b0, str_al, 4'h0, 1'b1, 1'b0, O_DEC, "str_decode");
        step(1'b0, str_al, 4'h0, 1'b1, 1'b0, O_MAD, "str_memadr");
        for (int i = 0; i < 2; i++) step(1'b0, str_al, 4'h0, 1'b0, 1'b0, O_MWR, "str_memwr_stall");
        step(1'b0, str_al, 4'h0, 1'b1, 1'b0, O_MWR, "str_memwr_done");

        step(1'b0, fop, 4'h0, 1'b1, 1'b0, O_FR,  "fpu_fetch");
        step(1'b0, fop, 4'h0, 1'b1, 1'b0, O_DEC, "fpu_decode");
        d2_flt = 1'b1;
        step(1'b0, fop, 4'h0, 1'b1, 1'b0, O_FXS, "fpu_start");
        step(1'b0, fop, 4'h0, 1'b1, 1'b0, O_FXI, "fpu_wait");
        step(1'b0, fop, 4'h0, 1'b1, 1'b1, O_FXI, "fpu_done");
        step(1'b0, fop, 4'h0, 1'b1, 1'b0, O_FWB, "fpu_writeback");

        for (int i = 0; i < 15; i++) step(1'b0, str_eq, 4'h0, 1'b0, 1'b0, O_FW, "fetch_wait_edge");
        step(1'b0, str_eq, 4'h0, 1'b1, 1'b0, O_FR,  "fetch_done_at_max");
        step(1'b0, str_eq, 4'h0, 1'b1, 1'b0, O_DEC, "fetch_after_max_decode");

        for (int i = 0; i < 16; i++) step(1'b0, str_eq, 4'h0, 1'b0, 1'b0, O_FW, "fetch_hang");
        for (int i = 0; i < 3; i++)  step(1'b0, str_eq, 4'h0, 1'b1, 1'b0, O_FLT, "fault_sticky");

        step(1'b1, str_eq, 4'h0, 1'b1, 1'b0, O_RST, "reset_from_fault");
        d2_flt = 1'b0;
        step(1'b0, str_eq, 4'h0, 1'b1, 1'b0, O_FR,  "fetch_after_reset");
        step(1'b0, str_eq, 4'h0, 1'b1, 1'b0, O_DEC, "decode_after_reset");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
